pipe_control: RTL
=================

// Module: pipe_control
// PURPOSE
// 5-stage pipelined control unit for the 64-bit LEGv8 core. Decodes the instruction in ID and
// carries its control bundle through ID/EX, EX/MEM and MEM/WB registers.
// Detects load-use hazards (stall + bubble), resolves B/CBZ in EX (flush of ID), and never drives X.
// Sits between the IF/ID register and the datapath stage registers.
// PARAMETERS
// REG_AW          5    register-address width (instr fields Rd/Rn/Rm/Rt)
// ALUOP_W         3    ALU opcode width
// ZERO_REG        31   register index hardwired to zero; never causes a hazard
// LOAD_USE_STALL  1    1: load-use interlock enabled; 0: stall_if tied 0 (software-scheduled)
// PORTS
// clk           in   1        clock, all state on rising edge
// reset_n       in   1        asynchronous active-low reset
// instr_id      in   32       instruction held in IF/ID
// valid_id      in   1        IF/ID holds a real instruction
// zero_ex       in   1        ALU zero flag for the instruction in EX
// reg2loc_id    out  1        regfile read-port-B select in ID (1=Rm, 0=Rt), combinational
// illegal_id    out  1        valid_id and opcode not in decode table, combinational
// stall_if      out  1        hold PC and IF/ID this cycle
// flush_ifid    out  1        squash the instruction in IF/ID (branch taken in EX)
// alusrc_ex     out  1        EX: ALU B from immediate
// alusrc1_ex    out  1        EX: immediate select (1=ALU imm12, 0=DT addr9)
// aluop_ex      out  ALUOP_W  EX: ALU operation
// br_taken_ex   out  1        EX: redirect PC
// uncond_br_ex  out  1        EX: target select (1=B imm26, 0=CBZ imm19)
// memwr_mem     out  1        MEM: data-memory write
// memrd_mem     out  1        MEM: data-memory read
// regwr_wb      out  1        WB: regfile write enable
// memtoreg_wb   out  1        WB: writeback from memory
// rd_wb         out  REG_AW   WB: destination register
// BEHAVIOUR
// Decode (instr[31:21]; cols reg2loc,alusrc,alusrc1,aluop,memrd,memwr,regwr,memtoreg,branch):
//   ADDS 10101011000: 1,0,0,010,0,0,1,0,-   SUBS 11101011000: 1,0,0,011,0,0,1,0,-
//   ADDI 1001000100x: 0,1,1,010,0,0,1,0,-   SUBI 1101000100x: 0,1,1,011,0,0,1,0,-
//   LDUR 11111000010: 0,1,0,010,1,0,1,1,-   STUR 11111000000: 0,1,0,010,0,1,0,0,-
//   B    000101xxxxx: 0,0,0,000,0,0,0,0,B   CBZ  10110100xxx: 0,0,0,000,0,0,0,0,CBZ
//   illegal / !valid_id: bubble (all enables 0, aluop 000); illegal_id=1 only if valid_id.
// Dest reg = instr[4:0]. Source regs: Rn=instr[9:5] (ALU, LDUR, STUR); Rm=instr[20:16] (ADDS/SUBS);
//   Rt=instr[4:0] (STUR, CBZ). B reads none.
// Pipeline: decode in cycle N -> EX outputs N+1, MEM N+2, WB N+3. Each stage register holds valid bit.
// Bubble = valid 0 and all write/branch enables 0; datapath selects forced 0.
// Load-use: hazard = LOAD_USE_STALL & valid_ex & memrd_ex & rd_ex!=ZERO_REG & rd_ex equals any
//   source of the valid ID instruction. Hazard -> stall_if=1, ID/EX loads bubble, EX/MEM+ advance.
//   Exactly one stall cycle per hazard.
// Branch: br_taken_ex = valid_ex & (is_b_ex | is_cbz_ex & zero_ex). uncond_br_ex = is_b_ex.
//   On br_taken_ex: flush_ifid=1; ID/EX loads bubble next edge; no stall that cycle.
// Priority: flush > stall (mutually exclusive by construction; flush wins regardless).
// EX/MEM, MEM/WB never stall; rd_wb holds last value when regwr_wb=0 (don't-care, but not X).
// Reset (async, any time incl. mid-stall): all stage valids 0, every registered output 0, rd_wb=0.
//   stall_if, flush_ifid = 0 while reset_n=0. Combinational outputs follow instr_id/valid_id.
// TESTING
// ADDI X1,X2,#5 (0x91001441) valid at N -> alusrc_ex=1, aluop_ex=010 at N+1; regwr_wb=1, rd_wb=1 at N+3.
// LDUR X3,[X4] then ADDS X5,X3,X6 -> stall_if=1 one cycle, EX bubble, ADDS reaches EX one cycle late.
// LDUR X31,[X4] then ADDS X5,X31,X6 -> no stall. With LOAD_USE_STALL=0, X3 case -> no stall.
// CBZ X7 in EX with zero_ex=1 -> br_taken_ex=1, uncond_br_ex=0, flush_ifid=1, next EX is bubble.
// CBZ with zero_ex=0 -> no flush. B -> br_taken_ex=1, uncond_br_ex=1.
// instr 0xFFFFFFFF valid -> illegal_id=1, all downstream enables 0. reset_n low mid-stall -> all 0, no X.

Source files
------------

// File: rtl/pipe_control.sv
// Pipelined control unit for a 5-stage LEGv8 core: decodes the IF/ID instruction and carries
// its control bundle through ID/EX, EX/MEM and MEM/WB, with load-use interlock and branch flush.
module pipe_control #(
  parameter int REG_AW         = 5,
  parameter int ALUOP_W        = 3,
  parameter int ZERO_REG       = 31,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        instr_id,
  input  logic               valid_id,
  input  logic               zero_ex,
  output logic               reg2loc_id,
  output logic               illegal_id,
  output logic               stall_if,
  output logic               flush_ifid,
  output logic               alusrc_ex,
  output logic               alusrc1_ex,
  output logic [ALUOP_W-1:0] aluop_ex,
  output logic               br_taken_ex,
  output logic               uncond_br_ex,
  output logic               memwr_mem,
  output logic               memrd_mem,
  output logic               regwr_wb,
  output logic               memtoreg_wb,
  output logic [REG_AW-1:0]  rd_wb
);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b011);
  localparam logic [REG_AW-1:0]  ZR      = REG_AW'(ZERO_REG);

  typedef struct packed {
    logic               legal;
    logic               reg2loc;
    logic               alusrc;
    logic               alusrc1;
    logic [ALUOP_W-1:0] aluop;
    logic               memrd;
    logic               memwr;
    logic               regwr;
    logic               memtoreg;
    logic               is_b;
    logic               is_cbz;
    logic               use_rn;
    logic               use_rm;
    logic               use_rt;
  } dec_t;

  typedef struct packed {
    logic               valid;
    logic               alusrc;
    logic               alusrc1;
    logic [ALUOP_W-1:0] aluop;
    logic               memrd;
    logic               memwr;
    logic               regwr;
    logic               memtoreg;
    logic               is_b;
    logic               is_cbz;
    logic [REG_AW-1:0]  rd;
  } idex_t;

  typedef struct packed {
    logic              valid;
    logic              memrd;
    logic              memwr;
    logic              regwr;
    logic              memtoreg;
    logic [REG_AW-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic              valid;
    logic              regwr;
    logic              memtoreg;
    logic [REG_AW-1:0] rd;
  } memwb_t;

  dec_t   dec;
  idex_t  ex, ex_next;
  exmem_t mem;
  memwb_t wb;

  logic [REG_AW-1:0] rn, rm, rt;
  logic              id_live, src_match, hazard;

  assign rn = instr_id[5  +: REG_AW];
  assign rm = instr_id[16 +: REG_AW];
  assign rt = instr_id[0  +: REG_AW];

  // NOTE: every field gets a default before the case so no path leaves a latch behind.
  always_comb begin
    dec = '0;
    casez (instr_id[31:21])
      11'b10101011000: begin  // ADDS
        dec.legal = 1'b1; dec.reg2loc = 1'b1; dec.aluop = ALU_ADD; dec.regwr = 1'b1;
        dec.use_rn = 1'b1; dec.use_rm = 1'b1;
      end
      11'b11101011000: begin  // SUBS
        dec.legal = 1'b1; dec.reg2loc = 1'b1; dec.aluop = ALU_SUB; dec.regwr = 1'b1;
        dec.use_rn = 1'b1; dec.use_rm = 1'b1;
      end
      11'b1001000100?: begin  // ADDI
        dec.legal = 1'b1; dec.alusrc = 1'b1; dec.alusrc1 = 1'b1; dec.aluop = ALU_ADD;
        dec.regwr = 1'b1; dec.use_rn = 1'b1;
      end
      11'b1101000100?: begin  // SUBI
        dec.legal = 1'b1; dec.alusrc = 1'b1; dec.alusrc1 = 1'b1; dec.aluop = ALU_SUB;
        dec.regwr = 1'b1; dec.use_rn = 1'b1;
      end
      11'b11111000010: begin  // LDUR
        dec.legal = 1'b1; dec.alusrc = 1'b1; dec.aluop = ALU_ADD; dec.memrd = 1'b1;
        dec.regwr = 1'b1; dec.memtoreg = 1'b1; dec.use_rn = 1'b1;
      end
      11'b11111000000: begin  // STUR
        dec.legal = 1'b1; dec.alusrc = 1'b1; dec.aluop = ALU_ADD; dec.memwr = 1'b1;
        dec.use_rn = 1'b1; dec.use_rt = 1'b1;
      end
      11'b000101?????: begin dec.legal = 1'b1; dec.is_b = 1'b1; end
      11'b10110100???: begin dec.legal = 1'b1; dec.is_cbz = 1'b1; dec.use_rt = 1'b1; end
      default: ;
    endcase
  end

  assign id_live    = valid_id & dec.legal;
  assign reg2loc_id = id_live & dec.reg2loc;
  assign illegal_id = valid_id & ~dec.legal;

  assign src_match = (dec.use_rn && rn == ex.rd) || (dec.use_rm && rm == ex.rd) ||
                     (dec.use_rt && rt == ex.rd);
  assign hazard    = (LOAD_USE_STALL != 0) && ex.valid && ex.memrd && (ex.rd != ZR) &&
                     id_live && src_match;

  assign br_taken_ex  = ex.valid & (ex.is_b | (ex.is_cbz & zero_ex));
  assign uncond_br_ex = ex.valid & ex.is_b;
  assign flush_ifid   = br_taken_ex;
  // A taken branch squashes the ID instruction, so a stall against it would be meaningless.
  assign stall_if     = hazard & ~flush_ifid;

  always_comb begin
    ex_next = '0;
    if (id_live && !flush_ifid && !stall_if) begin
      ex_next.valid    = 1'b1;
      ex_next.alusrc   = dec.alusrc;
      ex_next.alusrc1  = dec.alusrc1;
      ex_next.aluop    = dec.aluop;
      ex_next.memrd    = dec.memrd;
      ex_next.memwr    = dec.memwr;
      ex_next.regwr    = dec.regwr;
      ex_next.memtoreg = dec.memtoreg;
      ex_next.is_b     = dec.is_b;
      ex_next.is_cbz   = dec.is_cbz;
      ex_next.rd       = rt;
    end
  end

  // NOTE: state registers use non-blocking assignments so every stage samples the old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else begin
      ex           <= ex_next;
      mem.valid    <= ex.valid;
      mem.memrd    <= ex.memrd;
      mem.memwr    <= ex.memwr;
      mem.regwr    <= ex.regwr;
      mem.memtoreg <= ex.memtoreg;
      mem.rd       <= ex.rd;
      wb.valid     <= mem.valid;
      wb.regwr     <= mem.regwr;
      wb.memtoreg  <= mem.memtoreg;
      if (mem.regwr) wb.rd <= mem.rd;
    end
  end

  assign alusrc_ex   = ex.alusrc;
  assign alusrc1_ex  = ex.alusrc1;
  assign aluop_ex    = ex.aluop;
  assign memwr_mem   = mem.memwr;
  assign memrd_mem   = mem.memrd;
  assign regwr_wb    = wb.regwr;
  assign memtoreg_wb = wb.memtoreg;
  assign rd_wb       = wb.rd;

  logic unused_bits;
  assign unused_bits = ^{instr_id[15:10], wb.valid};

endmodule
